rs_ex_unit: RTL and testbench

RS_EX_UNIT -- requirements
Module: rs_ex_unit

---
 rtl/rs_ex_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_rs_ex_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_ex_unit.sv
// Two-stage integer execute unit for the reservation-station back end.
// E1 latches an issued op; E2 computes ALU/branch results and broadcasts them on the CDB.
module rs_ex_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_sign_from_rob,
    input  logic [5:0]  opnum_from_rs,
    input  logic [31:0] V1_from_rs,
    input  logic [31:0] V2_from_rs,
    input  logic [31:0] pc_from_rs,
    input  logic [31:0] imm_from_rs,
    input  logic [4:0]  rob_id_from_rs,
    output logic        valid_sign_to_cdb,
    output logic [4:0]  rob_id_to_cdb,
    output logic [31:0] data_to_cdb,
    output logic        jump_sign_to_rob,
    output logic [31:0] target_pc_to_rob
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 6;
    localparam int unsigned ROBW  = 5;
    localparam int unsigned SHW   = 5;

    localparam logic [ROBW-1:0] INVALID_ROB = ROBW'(0);

    localparam logic [OPW-1:0] OPNUM_NULL  = OPW'(0);
    localparam logic [OPW-1:0] OPNUM_LUI   = OPW'(1);
    localparam logic [OPW-1:0] OPNUM_AUIPC = OPW'(2);
    localparam logic [OPW-1:0] OPNUM_JAL   = OPW'(3);
    localparam logic [OPW-1:0] OPNUM_JALR  = OPW'(4);
    localparam logic [OPW-1:0] OPNUM_BEQ   = OPW'(5);
    localparam logic [OPW-1:0] OPNUM_BNE   = OPW'(6);
    localparam logic [OPW-1:0] OPNUM_BLT   = OPW'(7);
    localparam logic [OPW-1:0] OPNUM_BGE   = OPW'(8);
    localparam logic [OPW-1:0] OPNUM_BLTU  = OPW'(9);
    localparam logic [OPW-1:0] OPNUM_BGEU  = OPW'(10);
    localparam logic [OPW-1:0] OPNUM_ADDI  = OPW'(19);
    localparam logic [OPW-1:0] OPNUM_SLTI  = OPW'(20);
    localparam logic [OPW-1:0] OPNUM_SLTIU = OPW'(21);
    localparam logic [OPW-1:0] OPNUM_XORI  = OPW'(22);
    localparam logic [OPW-1:0] OPNUM_ORI   = OPW'(23);
    localparam logic [OPW-1:0] OPNUM_ANDI  = OPW'(24);
    localparam logic [OPW-1:0] OPNUM_SLLI  = OPW'(25);
    localparam logic [OPW-1:0] OPNUM_SRLI  = OPW'(26);
    localparam logic [OPW-1:0] OPNUM_SRAI  = OPW'(27);
    localparam logic [OPW-1:0] OPNUM_ADD   = OPW'(28);
    localparam logic [OPW-1:0] OPNUM_SUB   = OPW'(29);
    localparam logic [OPW-1:0] OPNUM_SLL   = OPW'(30);
    localparam logic [OPW-1:0] OPNUM_SLT   = OPW'(31);
    localparam logic [OPW-1:0] OPNUM_SLTU  = OPW'(32);
    localparam logic [OPW-1:0] OPNUM_XOR   = OPW'(33);
    localparam logic [OPW-1:0] OPNUM_SRL   = OPW'(34);
    localparam logic [OPW-1:0] OPNUM_SRA   = OPW'(35);
    localparam logic [OPW-1:0] OPNUM_OR    = OPW'(36);
    localparam logic [OPW-1:0] OPNUM_AND   = OPW'(37);

    // E1 issue latch
    logic            e1_valid_q, e1_valid_d;
    logic [OPW-1:0]  e1_op_q,    e1_op_d;
    logic [XLEN-1:0] e1_v1_q,    e1_v1_d;
    logic [XLEN-1:0] e1_v2_q,    e1_v2_d;
    logic [XLEN-1:0] e1_pc_q,    e1_pc_d;
    logic [XLEN-1:0] e1_imm_q,   e1_imm_d;
    logic [ROBW-1:0] e1_rob_q,   e1_rob_d;

    // E2 output registers
    logic            valid_q,  valid_d;
    logic [ROBW-1:0] rob_q,    rob_d;
    logic [XLEN-1:0] data_q,   data_d;
    logic            jump_q,   jump_d;
    logic [XLEN-1:0] target_q, target_d;

    // Execute datapath results
    logic            issue_c;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] pc_plus_imm_c;
    logic [XLEN-1:0] op_b_c;
    logic [SHW-1:0]  shamt_c;
    logic            lt_s_c;
    logic            lt_u_c;
    logic            eq_c;
    logic            is_branch_c;
    logic            taken_c;
    logic [XLEN-1:0] res_data_c;
    logic            res_jump_c;
    logic [XLEN-1:0] res_target_c;

    assign issue_c = (opnum_from_rs != OPNUM_NULL) && (rob_id_from_rs != INVALID_ROB);

    // E1 capture; rollback wins over a simultaneous issue
    always_comb begin
        e1_valid_d = e1_valid_q;
        e1_op_d    = e1_op_q;
        e1_v1_d    = e1_v1_q;
        e1_v2_d    = e1_v2_q;
        e1_pc_d    = e1_pc_q;
        e1_imm_d   = e1_imm_q;
        e1_rob_d   = e1_rob_q;
        if (rollback_sign_from_rob) begin
            e1_valid_d = 1'b0;
        end else if (rdy) begin
            e1_valid_d = issue_c;
            if (issue_c) begin
                e1_op_d  = opnum_from_rs;
                e1_v1_d  = V1_from_rs;
                e1_v2_d  = V2_from_rs;
                e1_pc_d  = pc_from_rs;
                e1_imm_d = imm_from_rs;
                e1_rob_d = rob_id_from_rs;
            end
        end
    end

    // Immediate forms take the second operand from imm
    always_comb begin
        op_b_c = e1_v2_q;
        if ((e1_op_q >= OPNUM_ADDI) && (e1_op_q <= OPNUM_SRAI)) begin
            op_b_c = e1_imm_q;
        end
    end

    assign pc_plus4_c    = e1_pc_q + XLEN'(4);
    assign pc_plus_imm_c = e1_pc_q + e1_imm_q;
    assign shamt_c       = op_b_c[SHW-1:0];
    assign lt_s_c        = $signed(e1_v1_q) < $signed(op_b_c);
    assign lt_u_c        = e1_v1_q < op_b_c;
    assign eq_c          = e1_v1_q == e1_v2_q;

    // Branch condition evaluation
    always_comb begin
        is_branch_c = 1'b1;
        taken_c     = 1'b0;
        case (e1_op_q)
            OPNUM_BEQ:  taken_c = eq_c;
            OPNUM_BNE:  taken_c = !eq_c;
            OPNUM_BLT:  taken_c = lt_s_c;
            OPNUM_BGE:  taken_c = !lt_s_c;
            OPNUM_BLTU: taken_c = lt_u_c;
            OPNUM_BGEU: taken_c = !lt_u_c;
            default:    is_branch_c = 1'b0;
        endcase
    end

    // ALU and control-transfer result selection; unknown ops broadcast zero
    always_comb begin
        res_data_c   = '0;
        res_jump_c   = 1'b0;
        res_target_c = pc_plus4_c;
        case (e1_op_q)
            OPNUM_LUI:   res_data_c = e1_imm_q;
            OPNUM_AUIPC: res_data_c = pc_plus_imm_c;
            OPNUM_JAL: begin
                res_data_c   = pc_plus4_c;
                res_jump_c   = 1'b1;
                res_target_c = pc_plus_imm_c;
            end
            OPNUM_JALR: begin
                res_data_c   = pc_plus4_c;
                res_jump_c   = 1'b1;
                res_target_c = (e1_v1_q + e1_imm_q) & ~XLEN'(1);
            end
            OPNUM_ADD,  OPNUM_ADDI:  res_data_c = e1_v1_q + op_b_c;
            OPNUM_SUB:               res_data_c = e1_v1_q - op_b_c;
            OPNUM_AND,  OPNUM_ANDI:  res_data_c = e1_v1_q & op_b_c;
            OPNUM_OR,   OPNUM_ORI:   res_data_c = e1_v1_q | op_b_c;
            OPNUM_XOR,  OPNUM_XORI:  res_data_c = e1_v1_q ^ op_b_c;
            OPNUM_SLL,  OPNUM_SLLI:  res_data_c = e1_v1_q << shamt_c;
            OPNUM_SRL,  OPNUM_SRLI:  res_data_c = e1_v1_q >> shamt_c;
            OPNUM_SRA,  OPNUM_SRAI:  res_data_c = $unsigned($signed(e1_v1_q) >>> shamt_c);
            OPNUM_SLT,  OPNUM_SLTI:  res_data_c = {{(XLEN-1){1'b0}}, lt_s_c};
            OPNUM_SLTU, OPNUM_SLTIU: res_data_c = {{(XLEN-1){1'b0}}, lt_u_c};
            default: begin
                if (is_branch_c) begin
                    res_jump_c   = taken_c;
                    res_target_c = taken_c ? pc_plus_imm_c : pc_plus4_c;
                end
            end
        endcase
    end

    // E2 output update; an empty E1 keeps data/target but drops valid and tag
    always_comb begin
        valid_d  = valid_q;
        rob_d    = rob_q;
        data_d   = data_q;
        jump_d   = jump_q;
        target_d = target_q;
        if (rollback_sign_from_rob) begin
            valid_d  = 1'b0;
            rob_d    = INVALID_ROB;
            data_d   = '0;
            jump_d   = 1'b0;
            target_d = '0;
        end else if (rdy) begin
            if (e1_valid_q) begin
                valid_d  = 1'b1;
                rob_d    = e1_rob_q;
                data_d   = res_data_c;
                jump_d   = res_jump_c;
                target_d = res_target_c;
            end else begin
                valid_d  = 1'b0;
                rob_d    = INVALID_ROB;
                jump_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            e1_valid_q <= 1'b0;
            e1_op_q    <= OPNUM_NULL;
            e1_v1_q    <= '0;
            e1_v2_q    <= '0;
            e1_pc_q    <= '0;
            e1_imm_q   <= '0;
            e1_rob_q   <= INVALID_ROB;
            valid_q    <= 1'b0;
            rob_q      <= INVALID_ROB;
            data_q     <= '0;
            jump_q     <= 1'b0;
            target_q   <= '0;
        end else begin
            e1_valid_q <= e1_valid_d;
            e1_op_q    <= e1_op_d;
            e1_v1_q    <= e1_v1_d;
            e1_v2_q    <= e1_v2_d;
            e1_pc_q    <= e1_pc_d;
            e1_imm_q   <= e1_imm_d;
            e1_rob_q   <= e1_rob_d;
            valid_q    <= valid_d;
            rob_q      <= rob_d;
            data_q     <= data_d;
            jump_q     <= jump_d;
            target_q   <= target_d;
        end
    end

    assign valid_sign_to_cdb = valid_q;
    assign rob_id_to_cdb     = rob_q;
    assign data_to_cdb       = data_q;
    assign jump_sign_to_rob  = jump_q;
    assign target_pc_to_rob  = target_q;

endmodule

// File: tb/tb_rs_ex_unit.sv
// Self-checking bench for rs_ex_unit: directed scenarios plus a randomized op stream
// compared against a behavioural model of the two-cycle execute pipeline.
module tb_rs_ex_unit;

    localparam logic [4:0] INVALID_ROB = 5'd0;
    localparam logic [5:0] OP_NULL = 6'd0,  OP_LUI = 6'd1,  OP_AUIPC = 6'd2, OP_JAL = 6'd3;
    localparam logic [5:0] OP_JALR = 6'd4,  OP_BEQ = 6'd5,  OP_BNE = 6'd6,   OP_BLT = 6'd7;
    localparam logic [5:0] OP_BGE = 6'd8,   OP_BLTU = 6'd9, OP_BGEU = 6'd10, OP_LW = 6'd13;
    localparam logic [5:0] OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22;
    localparam logic [5:0] OP_ORI = 6'd23,  OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26;
    localparam logic [5:0] OP_SRAI = 6'd27, OP_ADD = 6'd28,  OP_SUB = 6'd29,  OP_SLL = 6'd30;
    localparam logic [5:0] OP_SLT = 6'd31,  OP_SLTU = 6'd32, OP_XOR = 6'd33,  OP_SRL = 6'd34;
    localparam logic [5:0] OP_SRA = 6'd35,  OP_OR = 6'd36,   OP_AND = 6'd37;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic [5:0]  opnum;
    logic [31:0] v1, v2, pc, imm;
    logic [4:0]  rob_in;
    logic        valid_o, jump_o;
    logic [4:0]  rob_o;
    logic [31:0] data_o, target_o;

    int errors = 0;
    int checks = 0;

    rs_ex_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .rollback_sign_from_rob (rollback),
        .opnum_from_rs          (opnum),
        .V1_from_rs             (v1),
        .V2_from_rs             (v2),
        .pc_from_rs             (pc),
        .imm_from_rs            (imm),
        .rob_id_from_rs         (rob_in),
        .valid_sign_to_cdb      (valid_o),
        .rob_id_to_cdb          (rob_o),
        .data_to_cdb            (data_o),
        .jump_sign_to_rob       (jump_o),
        .target_pc_to_rob       (target_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, input logic [4:0] t);
        opnum = op; v1 = a; v2 = b; pc = p; imm = i; rob_in = t;
    endtask

    task automatic drive_null();
        drive(OP_NULL, 32'd0, 32'd0, 32'd0, 32'd0, INVALID_ROB);
    endtask

    // Issue one op, then let it travel to the outputs
    task automatic issue_one(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] p, input logic [31:0] i, input logic [4:0] t);
        drive(op, a, b, p, i, t);
        tick();
        drive_null();
        tick();
    endtask

    // Architectural result of one instruction
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] p, input logic [31:0] i,
                                  output logic [31:0] d, output logic j, output logic [31:0] t);
        logic [31:0] opb;
        logic [4:0]  sh;
        logic        take;
        logic        is_br;
        opb   = (op >= OP_ADDI && op <= OP_SRAI) ? i : b;
        sh    = opb[4:0];
        d     = 32'd0;
        j     = 1'b0;
        t     = p + 32'd4;
        take  = 1'b0;
        is_br = 1'b0;
        case (op)
            OP_LUI:   d = i;
            OP_AUIPC: d = p + i;
            OP_JAL:   begin d = p + 32'd4; j = 1'b1; t = p + i; end
            OP_JALR:  begin d = p + 32'd4; j = 1'b1; t = (a + i) - ((a + i) % 2); end
            OP_ADD, OP_ADDI: d = a + opb;
            OP_SUB:          d = a - opb;
            OP_AND, OP_ANDI: d = a & opb;
            OP_OR,  OP_ORI:  d = a | opb;
            OP_XOR, OP_XORI: d = a ^ opb;
            OP_SLL, OP_SLLI: d = a * (32'd1 << sh);
            OP_SRL, OP_SRLI: d = a / (32'd1 << sh);
            OP_SRA, OP_SRAI: d = a[31] ? ~((~a) >> sh) : (a >> sh);
            OP_SLT, OP_SLTI: d = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            OP_SLTU, OP_SLTIU: d = (a < opb) ? 32'd1 : 32'd0;
            OP_BEQ:  begin is_br = 1'b1; take = (a == b); end
            OP_BNE:  begin is_br = 1'b1; take = (a != b); end
            OP_BLT:  begin is_br = 1'b1; take = ($signed(a) < $signed(b)); end
            OP_BGE:  begin is_br = 1'b1; take = ($signed(a) >= $signed(b)); end
            OP_BLTU: begin is_br = 1'b1; take = (a < b); end
            OP_BGEU: begin is_br = 1'b1; take = (a >= b); end
            default: d = 32'd0;
        endcase
        if (is_br) begin
            j = take;
            t = take ? p + i : p + 32'd4;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; drive_null();
        tick(); tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_o); end
        checks++; if (rob_o !== INVALID_ROB) begin errors++; $display("FAIL reset_rob got %0d want %0d", rob_o, INVALID_ROB); end
        checks++; if (data_o !== 32'd0 || target_o !== 32'd0 || jump_o !== 1'b0) begin
            errors++; $display("FAIL reset_data data=%h tgt=%h jump=%0b want 0", data_o, target_o, jump_o);
        end
        rst = 1'b1;
        // Reset with rdy low while a result is on the bus
        issue_one(OP_ADD, 32'd40, 32'd2, 32'h50, 32'd0, 5'd2);
        rdy = 1'b0; rst = 1'b0; tick();
        checks++; if (valid_o !== 1'b0 || data_o !== 32'd0 || target_o !== 32'd0) begin
            errors++; $display("FAIL reset_rdy0 valid=%0b data=%h tgt=%h want 0", valid_o, data_o, target_o);
        end
        rst = 1'b1; rdy = 1'b1;
        // In-flight op in E1 at reset must vanish
        drive(OP_ADD, 32'd1, 32'd1, 32'h10, 32'd0, 5'd4); tick();
        drive_null(); rst = 1'b0; tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_inflight cyc%0d valid=%0b want 0", k, valid_o); end
        end
    endtask

    task automatic test_add_latency();
        drive(OP_ADD, 32'd5, 32'd7, 32'h40, 32'd0, 5'd3);
        tick();
        drive_null();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL add_cycle1 valid=%0b want 0", valid_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || rob_o !== 5'd3 || data_o !== 32'd12) begin
            errors++; $display("FAIL add_cycle2 valid=%0b rob=%0d data=%0d want 1/3/12", valid_o, rob_o, data_o);
        end
        checks++; if (jump_o !== 1'b0 || target_o !== 32'h44) begin
            errors++; $display("FAIL add_target jump=%0b tgt=%h want 0/44", jump_o, target_o);
        end
        tick();
        checks++; if (valid_o !== 1'b0 || rob_o !== INVALID_ROB || data_o !== 32'd12 || target_o !== 32'h44) begin
            errors++; $display("FAIL add_cycle3 valid=%0b rob=%0d data=%0d tgt=%h want 0/%0d/12/44",
                               valid_o, rob_o, data_o, target_o, INVALID_ROB);
        end
    endtask

    task automatic test_branch_jump();
        issue_one(OP_BEQ, 32'd9, 32'd9, 32'h100, 32'd8, 5'd6);
        checks++; if (valid_o !== 1'b1 || jump_o !== 1'b1 || target_o !== 32'h108 || data_o !== 32'd0) begin
            errors++; $display("FAIL beq_taken jump=%0b tgt=%h data=%h want 1/108/0", jump_o, target_o, data_o);
        end
        issue_one(OP_BEQ, 32'd9, 32'd1, 32'h100, 32'd8, 5'd6);
        checks++; if (valid_o !== 1'b1 || jump_o !== 1'b0 || target_o !== 32'h104 || data_o !== 32'd0) begin
            errors++; $display("FAIL beq_not_taken jump=%0b tgt=%h data=%h want 0/104/0", jump_o, target_o, data_o);
        end
        issue_one(OP_JALR, 32'h1003, 32'd0, 32'h200, 32'd4, 5'd8);
        checks++; if (data_o !== 32'h204 || target_o !== 32'h1006 || jump_o !== 1'b1) begin
            errors++; $display("FAIL jalr data=%h tgt=%h jump=%0b want 204/1006/1", data_o, target_o, jump_o);
        end
        issue_one(OP_JAL, 32'd0, 32'd0, 32'h300, 32'hFFFFFFF0, 5'd9);
        checks++; if (data_o !== 32'h304 || target_o !== 32'h2F0 || jump_o !== 1'b1) begin
            errors++; $display("FAIL jal data=%h tgt=%h jump=%0b want 304/2f0/1", data_o, target_o, jump_o);
        end
    endtask

    task automatic test_shift_compare();
        issue_one(OP_SRA, 32'h80000000, 32'h21, 32'h0, 32'd0, 5'd1);
        checks++; if (data_o !== 32'hC0000000) begin errors++; $display("FAIL sra data=%h want c0000000", data_o); end
        issue_one(OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'h0, 32'd0, 5'd1);
        checks++; if (data_o !== 32'd1) begin errors++; $display("FAIL sltu data=%h want 1", data_o); end
        issue_one(OP_SLT, 32'd1, 32'hFFFFFFFF, 32'h0, 32'd0, 5'd1);
        checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL slt data=%h want 0", data_o); end
        issue_one(OP_LUI, 32'd0, 32'd0, 32'h0, 32'hABCDE000, 5'd2);
        checks++; if (data_o !== 32'hABCDE000) begin errors++; $display("FAIL lui data=%h want abcde000", data_o); end
        issue_one(OP_LW, 32'd77, 32'd3, 32'h80, 32'd4, 5'd11);
        checks++; if (valid_o !== 1'b1 || rob_o !== 5'd11 || data_o !== 32'd0 || jump_o !== 1'b0) begin
            errors++; $display("FAIL undefined valid=%0b rob=%0d data=%h jump=%0b want 1/11/0/0", valid_o, rob_o, data_o, jump_o);
        end
    endtask

    task automatic test_rollback();
        drive(OP_ADD, 32'd1, 32'd2, 32'h20, 32'd0, 5'd4); tick();
        rollback = 1'b1;
        drive(OP_ADD, 32'd3, 32'd4, 32'h30, 32'd0, 5'd6); tick();
        rollback = 1'b0;
        checks++; if (valid_o !== 1'b0 || rob_o !== INVALID_ROB || data_o !== 32'd0 || target_o !== 32'd0 || jump_o !== 1'b0) begin
            errors++; $display("FAIL rollback_clear valid=%0b rob=%0d data=%h tgt=%h want reset values", valid_o, rob_o, data_o, target_o);
        end
        drive(OP_SUB, 32'd10, 32'd3, 32'h60, 32'd0, 5'd7); tick();
        drive_null();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rollback_drop valid=%0b rob=%0d want 0", valid_o, rob_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || rob_o !== 5'd7 || data_o !== 32'd7) begin
            errors++; $display("FAIL rollback_resume valid=%0b rob=%0d data=%0d want 1/7/7", valid_o, rob_o, data_o);
        end
        tick();
    endtask

    task automatic test_stall();
        int bc;
        bc = 0;
        drive(OP_ADD, 32'd10, 32'd20, 32'h70, 32'd0, 5'd9); tick();
        rdy = 1'b0;
        drive(OP_ADD, 32'd1, 32'd1, 32'h74, 32'd0, 5'd10);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (valid_o === 1'b1) bc++;
            checks++; if (valid_o !== 1'b0 || rob_o !== INVALID_ROB) begin
                errors++; $display("FAIL stall_frozen cyc%0d valid=%0b rob=%0d want 0/%0d", k, valid_o, rob_o, INVALID_ROB);
            end
        end
        rdy = 1'b1; drive_null(); tick();
        if (valid_o === 1'b1) bc++;
        checks++; if (valid_o !== 1'b1 || rob_o !== 5'd9 || data_o !== 32'd30) begin
            errors++; $display("FAIL stall_resume valid=%0b rob=%0d data=%0d want 1/9/30", valid_o, rob_o, data_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (valid_o === 1'b1) bc++;
        end
        checks++; if (bc != 1) begin errors++; $display("FAIL stall_broadcasts got %0d want 1", bc); end
        // A valid result stays asserted while rdy is low
        issue_one(OP_XOR, 32'hF0, 32'hFF, 32'h90, 32'd0, 5'd12);
        rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (valid_o !== 1'b1 || rob_o !== 5'd12 || data_o !== 32'h0F) begin
                errors++; $display("FAIL stall_hold cyc%0d valid=%0b rob=%0d data=%h want 1/12/0f", k, valid_o, rob_o, data_o);
            end
        end
        rdy = 1'b1; tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_release valid=%0b want 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 32'd1, 32'd1, 32'h0, 32'd0, 5'd5); tick();
        drive(OP_ADD, 32'd2, 32'd2, 32'h0, 32'd0, 5'd5); tick();
        drive_null();
        checks++; if (valid_o !== 1'b1 || rob_o !== 5'd5 || data_o !== 32'd2) begin
            errors++; $display("FAIL b2b_first valid=%0b rob=%0d data=%0d want 1/5/2", valid_o, rob_o, data_o);
        end
        tick();
        checks++; if (valid_o !== 1'b1 || rob_o !== 5'd5 || data_o !== 32'd4) begin
            errors++; $display("FAIL b2b_second valid=%0b rob=%0d data=%0d want 1/5/4", valid_o, rob_o, data_o);
        end
        tick();
    endtask

    task automatic test_random();
        logic        pend_v;
        logic [5:0]  p_op;
        logic [31:0] p_a, p_b, p_pc, p_imm;
        logic [4:0]  p_t;
        logic        e_v, e_j;
        logic [4:0]  e_rob;
        logic [31:0] e_d, e_t, m_d, m_t;
        logic        m_j;
        rst = 1'b0; drive_null(); tick(); rst = 1'b1;
        pend_v = 1'b0; p_op = OP_NULL; p_a = 0; p_b = 0; p_pc = 0; p_imm = 0; p_t = 0;
        e_d = 32'd0; e_t = 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            drive(6'($urandom_range(0, 40)), ra, rb, $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom))) : $urandom,
                  ($urandom_range(0, 7) == 0) ? INVALID_ROB : 5'($urandom_range(1, 31)));
            tick();
            if (pend_v) begin
                model(p_op, p_a, p_b, p_pc, p_imm, m_d, m_j, m_t);
                e_v = 1'b1; e_rob = p_t; e_d = m_d; e_j = m_j; e_t = m_t;
            end else begin
                e_v = 1'b0; e_rob = INVALID_ROB; e_j = 1'b0;
            end
            pend_v = (opnum != OP_NULL) && (rob_in != INVALID_ROB);
            p_op = opnum; p_a = v1; p_b = v2; p_pc = pc; p_imm = imm; p_t = rob_in;
            checks++;
            if (valid_o !== e_v || rob_o !== e_rob || data_o !== e_d || jump_o !== e_j || target_o !== e_t) begin
                errors++;
                $display("FAIL random_%0d got v=%0b rob=%0d d=%h j=%0b t=%h want v=%0b rob=%0d d=%h j=%0b t=%h",
                         n, valid_o, rob_o, data_o, jump_o, target_o, e_v, e_rob, e_d, e_j, e_t);
            end
        end
        drive_null(); tick(); tick();
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
        drive_null();
        test_reset();
        test_add_latency();
        test_branch_jump();
        test_shift_compare();
        test_rollback();
        test_stall();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
